// File: rtl/ped_request_ctrl_if.sv
// Signal bundle between the pedestrian-request controller and the traffic/button side.
interface ped_request_ctrl_if;
    logic       ped_req;
    logic [1:0] traffic_light;
    logic       hold_red;
    logic       walk;
    logic       dont_walk;
    logic       ped_pending;
    logic       ped_served;

    modport master (
        output ped_req, traffic_light,
        input  hold_red, walk, dont_walk, ped_pending, ped_served
    );

    modport slave (
        input  ped_req, traffic_light,
        output hold_red, walk, dont_walk, ped_pending, ped_served
    );
endinterface

// File: rtl/ped_request_ctrl.sv
// Pedestrian-request controller: latches button requests, holds the light red, runs WALK/CLEAR/COOLDOWN.
// Optional PED_FLASH_EN: dont_walk flashes during CLEAR.
module ped_request_ctrl #(
    parameter int CNT_W            = 16,
    parameter int WALK_CYCLES      = 8,
    parameter int CLEAR_CYCLES     = 4,
    parameter int MIN_GREEN_CYCLES = 6
) (
    input  logic              clk_main,
    input  logic              rst_main,
    ped_request_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RED, S_WALK, S_CLEAR, S_COOLDOWN
    } state_e;

    localparam logic [1:0]       TL_RED   = 2'b10;
    localparam logic [CNT_W-1:0] WALK_LD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LD  = CNT_W'(MIN_GREEN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_red_q, hold_red_d;
    logic             walk_q, walk_d;
    logic             dont_walk_q, dont_walk_d;
    logic             pend_q, pend_d;
    logic             served_q, served_d;
    logic             cnt_zero;
    logic             walk_entry;
`ifdef PED_FLASH_EN
    logic             flash_q, flash_d;
`endif

    assign cnt_zero   = (cnt_q == '0);
    assign walk_entry = (state_q == S_WAIT_RED) && (state_d == S_WALK);

    always_ff @(posedge clk_main) begin
        if (rst_main) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hold_red_q  <= 1'b0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            pend_q      <= 1'b0;
            served_q    <= 1'b0;
`ifdef PED_FLASH_EN
            flash_q     <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_red_q  <= hold_red_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            pend_q      <= pend_d;
            served_q    <= served_d;
`ifdef PED_FLASH_EN
            flash_q     <= flash_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (bus.ped_req || pend_q) state_d = S_WAIT_RED;
            S_WAIT_RED: if (bus.traffic_light == TL_RED) state_d = S_WALK;
            S_WALK:     if (cnt_zero) state_d = S_CLEAR;
            S_CLEAR:    if (cnt_zero) state_d = S_COOLDOWN;
            // A request arriving on the final cooldown edge still counts.
            S_COOLDOWN: if (cnt_zero) state_d = (bus.ped_req || pend_q) ? S_WAIT_RED : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            case (state_d)
                S_WALK:     cnt_d = WALK_LD;
                S_CLEAR:    cnt_d = CLEAR_LD;
                S_COOLDOWN: cnt_d = COOL_LD;
                default:    cnt_d = cnt_q;
            endcase
        end else if (!cnt_zero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // Clearing on WALK entry takes priority over a same-edge request.
        pend_d = pend_q;
        if (walk_entry)
            pend_d = 1'b0;
        else if (bus.ped_req && (state_q != S_WALK))
            pend_d = 1'b1;

        hold_red_d  = (state_d == S_WAIT_RED) || (state_d == S_WALK) || (state_d == S_CLEAR);
        walk_d      = (state_d == S_WALK);
        served_d    = walk_entry;
        dont_walk_d = (state_d != S_WALK);
`ifdef PED_FLASH_EN
        flash_d = 1'b1;
        if ((state_q == S_CLEAR) && (state_d == S_CLEAR))
            flash_d = ~flash_q;
        if (state_d == S_CLEAR)
            dont_walk_d = flash_d;
`endif
    end

    assign bus.hold_red    = hold_red_q;
    assign bus.walk        = walk_q;
    assign bus.dont_walk   = dont_walk_q;
    assign bus.ped_pending = pend_q;
    assign bus.ped_served  = served_q;
endmodule
